batrider_pcm_arb: RTL and testbench

Arbitrates one SDRAM PCM read port between the two jt6295 ADPCM channels. The channels' NMK112 banked addresses feed in, and each requester gets an ok/data pair back. Each requester has a single-entry tag cache, so repeated reads of the same byte never reach SDRAM. Misses are served round-robin through a 3-state fetch FSM. Sits between the two NMK112 bank translators and the SDRAM PCM slot.

---
 rtl/batrider_pcm_arb_if.sv | 27 ++
 rtl/batrider_pcm_arb.sv | 93 +++++++++
 tb/tb_batrider_pcm_arb.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/batrider_pcm_arb_if.sv
// batrider_pcm_arb_if: requester, SDRAM and status signals of batrider_pcm_arb.
interface batrider_pcm_arb_if #(
  parameter int AW = 21,
  parameter int DW = 8
);
  logic          REQ0_CS;
  logic [AW-1:0] REQ0_ADDR;
  logic          REQ0_OK;
  logic [DW-1:0] REQ0_DOUT;
  logic          REQ1_CS;
  logic [AW-1:0] REQ1_ADDR;
  logic          REQ1_OK;
  logic [DW-1:0] REQ1_DOUT;
  logic          ROM_CS;
  logic [AW-1:0] ROM_ADDR;
  logic          ROM_OK;
  logic [DW-1:0] ROM_DOUT;
  logic          TIMEOUT_ERR;
  modport slave (
    input  REQ0_CS, REQ0_ADDR, REQ1_CS, REQ1_ADDR, ROM_OK, ROM_DOUT,
    output REQ0_OK, REQ0_DOUT, REQ1_OK, REQ1_DOUT, ROM_CS, ROM_ADDR, TIMEOUT_ERR
  );
  modport master (
    output REQ0_CS, REQ0_ADDR, REQ1_CS, REQ1_ADDR, ROM_OK, ROM_DOUT,
    input  REQ0_OK, REQ0_DOUT, REQ1_OK, REQ1_DOUT, ROM_CS, ROM_ADDR, TIMEOUT_ERR
  );
endinterface

// File: rtl/batrider_pcm_arb.sv
// batrider_pcm_arb: round-robin SDRAM PCM read arbiter with a one-entry byte cache per requester.
// Define PCM_ARB_TIMEOUT_EN to bound WAIT at TIMEOUT cycles, filling silence and raising TIMEOUT_ERR.
module batrider_pcm_arb #(
  parameter int AW = 21,
  parameter int DW = 8,
  parameter int TIMEOUT = 255
) (
  input logic CLK96,
  input logic RESET96,
  batrider_pcm_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t        r_state;
  logic          r_sel;
  logic          r_ptr;
  logic          r_rom_cs;
  logic [AW-1:0] r_rom_addr;
  logic [AW-1:0] r_tag [2];
  logic [DW-1:0] r_data [2];
  logic [1:0]    r_valid;
  logic [1:0]    w_hit;
  logic [1:0]    w_miss;
  logic          w_sel;
  logic          w_fill;
  assign w_hit[0] = bus.REQ0_CS & r_valid[0] & (r_tag[0] == bus.REQ0_ADDR);
  assign w_hit[1] = bus.REQ1_CS & r_valid[1] & (r_tag[1] == bus.REQ1_ADDR);
  assign w_miss = {bus.REQ1_CS, bus.REQ0_CS} & ~w_hit;
  assign w_sel = &w_miss ? r_ptr : w_miss[1];
  assign bus.REQ0_OK = w_hit[0];
  assign bus.REQ1_OK = w_hit[1];
  assign bus.REQ0_DOUT = r_data[0];
  assign bus.REQ1_DOUT = r_data[1];
  assign bus.ROM_CS = r_rom_cs;
  assign bus.ROM_ADDR = r_rom_addr;
`ifdef PCM_ARB_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_err;
  logic       w_timeout;
  assign w_timeout = (r_state == WAIT) & ~bus.ROM_OK & (r_cnt == 8'(TIMEOUT - 1));
  assign w_fill = ((r_state == WAIT) & bus.ROM_OK) | w_timeout;
  assign bus.TIMEOUT_ERR = r_err;
`else
  assign w_fill = (r_state == WAIT) & bus.ROM_OK;
  assign bus.TIMEOUT_ERR = TIMEOUT < 0;
`endif
  always_ff @(posedge CLK96) begin
    if (RESET96) begin
      r_state <= IDLE;
      r_sel <= 1'b0;
      r_ptr <= 1'b0;
      r_rom_cs <= 1'b0;
      r_rom_addr <= '0;
      r_tag <= '{default: '0};
      r_data <= '{default: '0};
      r_valid <= '0;
`ifdef PCM_ARB_TIMEOUT_EN
      r_cnt <= '0;
      r_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (|w_miss) begin
          r_sel <= w_sel;
          r_rom_addr <= w_sel ? bus.REQ1_ADDR : bus.REQ0_ADDR;
          r_rom_cs <= 1'b1;
          r_state <= ISSUE;
        end
        ISSUE: begin
          r_state <= WAIT;
`ifdef PCM_ARB_TIMEOUT_EN
          r_cnt <= '0;
`endif
        end
        WAIT: begin
          // a timeout fill stores zero data: silent ADPCM nibbles
          if (w_fill) begin
            r_tag[r_sel] <= r_rom_addr;
            r_data[r_sel] <= bus.ROM_OK ? bus.ROM_DOUT : '0;
            r_valid[r_sel] <= 1'b1;
            r_rom_cs <= 1'b0;
            r_ptr <= ~r_sel;
            r_state <= IDLE;
          end
`ifdef PCM_ARB_TIMEOUT_EN
          r_cnt <= r_cnt + 8'd1;
          if (w_timeout) r_err <= 1'b1;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_batrider_pcm_arb.sv
// tb_batrider_pcm_arb: directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_batrider_pcm_arb;
`ifdef PCM_ARB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  batrider_pcm_arb_if #(.AW(21), .DW(8)) bus ();
  batrider_pcm_arb #(.AW(21), .DW(8), .TIMEOUT(TMO)) dut (.CLK96(clk), .RESET96(rst), .bus(bus));
  always #5 clk = ~clk;

  // reference model: cache contents plus one outstanding fetch and its age in cycles since it was latched
  logic [20:0] m_tag [2];
  logic [7:0]  m_data [2];
  bit          m_valid [2];
  bit          m_busy, m_sel, m_ptr, m_err;
  int          m_age;
  logic [20:0] m_addr;

  function automatic bit m_hit(int n, bit cs, logic [20:0] a);
    return cs && m_valid[n] && (m_tag[n] == a);
  endfunction

  function automatic logic [40:0] m_expect();
    return {m_hit(0, bus.REQ0_CS, bus.REQ0_ADDR), m_data[0], m_hit(1, bus.REQ1_CS, bus.REQ1_ADDR), m_data[1],
            m_busy, m_addr, m_err};
  endfunction

  task automatic m_fill(logic [7:0] d);
    m_tag[m_sel] = m_addr;
    m_data[m_sel] = d;
    m_valid[m_sel] = 1'b1;
    m_ptr = !m_sel;
    m_busy = 1'b0;
  endtask

  task automatic m_step();
    bit ms0, ms1;
    ms0 = bus.REQ0_CS && !m_hit(0, bus.REQ0_CS, bus.REQ0_ADDR);
    ms1 = bus.REQ1_CS && !m_hit(1, bus.REQ1_CS, bus.REQ1_ADDR);
    if (rst) begin
      for (int i = 0; i < 2; i++) begin m_tag[i] = '0; m_data[i] = '0; m_valid[i] = 1'b0; end
      m_busy = 0; m_sel = 0; m_ptr = 0; m_err = 0; m_age = 0; m_addr = '0;
    end else if (!m_busy) begin
      if (ms0 || ms1) begin
        m_sel = (ms0 && ms1) ? m_ptr : ms1;
        m_addr = m_sel ? bus.REQ1_ADDR : bus.REQ0_ADDR;
        m_busy = 1'b1;
        m_age = 0;
      end
    end else if (m_age > 0 && bus.ROM_OK) m_fill(bus.ROM_DOUT);
`ifdef PCM_ARB_TIMEOUT_EN
    else if (m_age == TMO) begin m_fill(8'h00); m_err = 1'b1; end
`endif
    else m_age++;
  endtask

  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit cs0, logic [20:0] a0, bit cs1, logic [20:0] a1, bit ok, logic [7:0] d);
    bus.REQ0_CS = cs0; bus.REQ0_ADDR = a0; bus.REQ1_CS = cs1; bus.REQ1_ADDR = a1;
    bus.ROM_OK = ok; bus.ROM_DOUT = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 8'h00);
    do_reset();
    n_cmp++; if ({bus.ROM_CS, bus.ROM_ADDR} !== 22'h0) begin n_err++; $display("FAIL reset_rom: got cs=%b addr=%h want 0/0", bus.ROM_CS, bus.ROM_ADDR); end
    n_cmp++; if ({bus.REQ0_OK, bus.REQ1_OK, bus.REQ0_DOUT, bus.REQ1_DOUT, bus.TIMEOUT_ERR} !== 19'h0) begin n_err++; $display("FAIL reset_outs: got ok=%b%b dout=%h/%h err=%b want all 0", bus.REQ0_OK, bus.REQ1_OK, bus.REQ0_DOUT, bus.REQ1_DOUT, bus.TIMEOUT_ERR); end
    bus.REQ0_CS = 1'b1;
    #1;
    n_cmp++; if (bus.REQ0_OK !== 1'b0) begin n_err++; $display("FAIL reset_invalid_tag0: got ok=%b want 0", bus.REQ0_OK); end
  endtask

  task automatic test_single_miss();
    do_reset();
    drive(1, 21'h001234, 0, 0, 1, 8'hA5);
    #1;
    n_cmp++; if ({bus.REQ0_OK, bus.ROM_CS} !== 2'b00) begin n_err++; $display("FAIL miss_cycle_n: got ok=%b cs=%b want 0/0", bus.REQ0_OK, bus.ROM_CS); end
    tick();
    n_cmp++; if ({bus.ROM_CS, bus.ROM_ADDR} !== {1'b1, 21'h001234}) begin n_err++; $display("FAIL miss_issue: got cs=%b addr=%h want 1/001234", bus.ROM_CS, bus.ROM_ADDR); end
    tick();
    n_cmp++; if (bus.REQ0_OK !== 1'b0) begin n_err++; $display("FAIL miss_early_ok: got %b want 0", bus.REQ0_OK); end
    tick();
    n_cmp++; if ({bus.REQ0_OK, bus.REQ0_DOUT, bus.ROM_CS} !== {1'b1, 8'hA5, 1'b0}) begin n_err++; $display("FAIL miss_fill: got ok=%b dout=%h cs=%b want 1/a5/0", bus.REQ0_OK, bus.REQ0_DOUT, bus.ROM_CS); end
  endtask

  task automatic test_hit();
    bus.ROM_OK = 1'b0; bus.ROM_DOUT = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++; if ({bus.ROM_CS, bus.REQ0_OK, bus.REQ0_DOUT} !== {1'b0, 1'b1, 8'hA5}) begin n_err++; $display("FAIL hit_hold[%0d]: got cs=%b ok=%b dout=%h want 0/1/a5", i, bus.ROM_CS, bus.REQ0_OK, bus.REQ0_DOUT); end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    drive(1, 21'h000010, 1, 21'h100020, 1, 8'h11);
    #1;
    tick();
    n_cmp++; if (bus.ROM_ADDR !== 21'h000010) begin n_err++; $display("FAIL rr_first: got %h want 000010", bus.ROM_ADDR); end
    tick(); tick();
    n_cmp++; if ({bus.REQ0_OK, bus.REQ0_DOUT, bus.REQ1_OK} !== {1'b1, 8'h11, 1'b0}) begin n_err++; $display("FAIL rr_fill0: got ok0=%b d0=%h ok1=%b want 1/11/0", bus.REQ0_OK, bus.REQ0_DOUT, bus.REQ1_OK); end
    bus.REQ0_ADDR = 21'h000011; bus.ROM_DOUT = 8'h22;
    #1;
    tick();
    n_cmp++; if (bus.ROM_ADDR !== 21'h100020) begin n_err++; $display("FAIL rr_repeat_req1_first: got %h want 100020", bus.ROM_ADDR); end
    tick(); tick();
    n_cmp++; if ({bus.REQ1_OK, bus.REQ1_DOUT, bus.REQ0_OK} !== {1'b1, 8'h22, 1'b0}) begin n_err++; $display("FAIL rr_fill1: got ok1=%b d1=%h ok0=%b want 1/22/0", bus.REQ1_OK, bus.REQ1_DOUT, bus.REQ0_OK); end
    bus.ROM_DOUT = 8'h33;
    tick();
    n_cmp++; if (bus.ROM_ADDR !== 21'h000011) begin n_err++; $display("FAIL rr_back_to_back: got %h want 000011", bus.ROM_ADDR); end
    tick(); tick();
    n_cmp++; if ({bus.REQ0_OK, bus.REQ0_DOUT, bus.REQ1_OK, bus.REQ1_DOUT} !== {1'b1, 8'h33, 1'b1, 8'h22}) begin n_err++; $display("FAIL rr_both_cached: got %b/%h %b/%h want 1/33 1/22", bus.REQ0_OK, bus.REQ0_DOUT, bus.REQ1_OK, bus.REQ1_DOUT); end
  endtask

  task automatic test_mid_fetch_change();
    do_reset();
    drive(0, 0, 1, 21'h100000, 0, 8'h3C);
    #1;
    tick(); tick();
    bus.REQ1_ADDR = 21'h100001; bus.ROM_OK = 1'b1;
    #1;
    tick();
    n_cmp++; if ({bus.REQ1_OK, bus.ROM_CS} !== 2'b00) begin n_err++; $display("FAIL stale_fill_ok: got ok1=%b cs=%b want 0/0", bus.REQ1_OK, bus.ROM_CS); end
    bus.REQ1_ADDR = 21'h100000;
    #1;
    n_cmp++; if ({bus.REQ1_OK, bus.REQ1_DOUT} !== {1'b1, 8'h3C}) begin n_err++; $display("FAIL stale_fill_tag: got ok1=%b d1=%h want 1/3c", bus.REQ1_OK, bus.REQ1_DOUT); end
    bus.REQ1_ADDR = 21'h100001; bus.ROM_DOUT = 8'h4D;
    #1;
    tick();
    n_cmp++; if ({bus.ROM_CS, bus.ROM_ADDR} !== {1'b1, 21'h100001}) begin n_err++; $display("FAIL refetch_issue: got cs=%b addr=%h want 1/100001", bus.ROM_CS, bus.ROM_ADDR); end
    tick(); tick();
    n_cmp++; if ({bus.REQ1_OK, bus.REQ1_DOUT} !== {1'b1, 8'h4D}) begin n_err++; $display("FAIL refetch_fill: got ok1=%b d1=%h want 1/4d", bus.REQ1_OK, bus.REQ1_DOUT); end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    drive(1, 21'h000054, 0, 0, 1, 8'h66);
    #1;
    tick(); tick(); tick();
    n_cmp++; if (bus.REQ0_OK !== 1'b1) begin n_err++; $display("FAIL rst_prefill: got %b want 1", bus.REQ0_OK); end
    bus.REQ0_ADDR = 21'h000055; bus.ROM_OK = 1'b0;
    #1;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if ({bus.ROM_CS, bus.REQ0_OK, bus.REQ1_OK} !== 3'b000) begin n_err++; $display("FAIL rst_abandon: got cs=%b ok=%b%b want 0/00", bus.ROM_CS, bus.REQ0_OK, bus.REQ1_OK); end
    bus.REQ0_ADDR = 21'h000054;
    #1;
    n_cmp++; if (bus.REQ0_OK !== 1'b0) begin n_err++; $display("FAIL rst_invalidate: got %b want 0", bus.REQ0_OK); end
    bus.REQ0_ADDR = 21'h000055; bus.ROM_OK = 1'b1; bus.ROM_DOUT = 8'h77;
    #1;
    tick();
    n_cmp++; if ({bus.ROM_CS, bus.ROM_ADDR} !== {1'b1, 21'h000055}) begin n_err++; $display("FAIL rst_refetch: got cs=%b addr=%h want 1/000055", bus.ROM_CS, bus.ROM_ADDR); end
    tick(); tick();
    n_cmp++; if ({bus.REQ0_OK, bus.REQ0_DOUT} !== {1'b1, 8'h77}) begin n_err++; $display("FAIL rst_refill: got ok=%b dout=%h want 1/77", bus.REQ0_OK, bus.REQ0_DOUT); end
  endtask

`ifdef PCM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    drive(1, 21'h000098, 0, 0, 1, 8'h5A);
    #1;
    tick(); tick(); tick();
    n_cmp++; if ({bus.REQ0_OK, bus.REQ0_DOUT} !== {1'b1, 8'h5A}) begin n_err++; $display("FAIL to_prefill: got ok=%b dout=%h want 1/5a", bus.REQ0_OK, bus.REQ0_DOUT); end
    bus.REQ0_ADDR = 21'h000099; bus.ROM_OK = 1'b0;
    #1;
    repeat (9) tick();
    n_cmp++; if ({bus.REQ0_OK, bus.ROM_CS, bus.TIMEOUT_ERR} !== 3'b010) begin n_err++; $display("FAIL to_before: got ok=%b cs=%b err=%b want 0/1/0", bus.REQ0_OK, bus.ROM_CS, bus.TIMEOUT_ERR); end
    tick();
    n_cmp++; if ({bus.REQ0_OK, bus.REQ0_DOUT, bus.ROM_CS, bus.TIMEOUT_ERR} !== {1'b1, 8'h00, 1'b0, 1'b1}) begin n_err++; $display("FAIL to_fire: got ok=%b dout=%h cs=%b err=%b want 1/00/0/1", bus.REQ0_OK, bus.REQ0_DOUT, bus.ROM_CS, bus.TIMEOUT_ERR); end
    bus.REQ0_ADDR = 21'h000100; bus.ROM_OK = 1'b1; bus.ROM_DOUT = 8'h12;
    #1;
    tick(); tick(); tick();
    n_cmp++; if ({bus.REQ0_OK, bus.REQ0_DOUT, bus.TIMEOUT_ERR} !== {1'b1, 8'h12, 1'b1}) begin n_err++; $display("FAIL to_sticky: got ok=%b dout=%h err=%b want 1/12/1", bus.REQ0_OK, bus.REQ0_DOUT, bus.TIMEOUT_ERR); end
  endtask
`else
  task automatic test_wait_forever();
    do_reset();
    drive(1, 21'h000099, 0, 0, 0, 8'h00);
    #1;
    repeat (300) tick();
    n_cmp++; if ({bus.REQ0_OK, bus.ROM_CS, bus.ROM_ADDR, bus.TIMEOUT_ERR} !== {1'b0, 1'b1, 21'h000099, 1'b0}) begin n_err++; $display("FAIL wait_forever: got ok=%b cs=%b addr=%h err=%b want 0/1/000099/0", bus.REQ0_OK, bus.ROM_CS, bus.ROM_ADDR, bus.TIMEOUT_ERR); end
  endtask
`endif

  task automatic test_random();
    logic [40:0] exp_v, got_v;
    drive(0, 0, 0, 0, 0, 8'h00);
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) bus.REQ0_ADDR = 21'h000100 + 21'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) bus.REQ1_ADDR = 21'h1F0000 + 21'($urandom_range(0, 3));
      bus.REQ0_CS = $urandom_range(0, 7) != 0;
      bus.REQ1_CS = $urandom_range(0, 7) != 0;
      bus.ROM_OK = $urandom_range(0, 3) == 0;
      bus.ROM_DOUT = 8'($urandom);
      rst = $urandom_range(0, 59) == 0;
      #1;
      exp_v = m_expect();
      got_v = {bus.REQ0_OK, bus.REQ0_DOUT, bus.REQ1_OK, bus.REQ1_DOUT, bus.ROM_CS, bus.ROM_ADDR, bus.TIMEOUT_ERR};
      n_cmp++; if (got_v !== exp_v) begin n_err++; $display("FAIL random[%0d] {ok0,d0,ok1,d1,cs,addr,err}: got %h want %h", i, got_v, exp_v); end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 8'h00);
    test_reset();
    test_single_miss();
    test_hit();
    test_round_robin();
    test_mid_fetch_change();
    test_reset_mid_fetch();
`ifdef PCM_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_wait_forever();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
